// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU types for the memory/writeback slice.
//   WORD_W      : data/address width
//   word_t      : one data word
//   regbits_t   : register file index
//   memtoreg_t  : writeback source select (ALU, load, LUI, PC+4)
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    ALU_SEL  = 2'd0,
    LOAD_SEL = 2'd1,
    LUI_SEL  = 2'd2,
    PC4_SEL  = 2'd3
  } memtoreg_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of the EX/MEM inputs, dcache request/response and MEM/WB outputs
// seen by the memory stage.
//   slave  : the memory stage view (EX/MEM + dcache response in, requests + MEM/WB out)
//   master : the surrounding pipeline / cache view
interface mem_wb_stage_if;
  import cpu_types_pkg::*;

  // pipeline strobe and dcache response
  logic       ihit;
  logic       dhit;
  word_t      dmemload;
  // EX/MEM latch
  logic       dREN_in;
  logic       dWEN_in;
  word_t      dmemstore_in;
  word_t      portO_in;
  logic       RegWr_in;
  logic [1:0] MemToReg_in;
  word_t      luiValue_in;
  word_t      pcp4_in;
  regbits_t   wsel_in;
  logic       halt_in;
  // dcache request
  logic       dmemREN;
  logic       dmemWEN;
  word_t      dmemaddr;
  word_t      dmemstore;
  // hazard
  logic       mem_stall;
  // MEM/WB latch
  logic       RegWr_out;
  regbits_t   wsel_out;
  word_t      wdat_out;
  logic       halt_out;

  modport slave (
    input  ihit, dhit, dmemload,
    input  dREN_in, dWEN_in, dmemstore_in, portO_in, RegWr_in, MemToReg_in,
    input  luiValue_in, pcp4_in, wsel_in, halt_in,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
    output RegWr_out, wsel_out, wdat_out, halt_out
  );

  modport master (
    output ihit, dhit, dmemload,
    output dREN_in, dWEN_in, dmemstore_in, portO_in, RegWr_in, MemToReg_in,
    output luiValue_in, pcp4_in, wsel_in, halt_in,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
    input  RegWr_out, wsel_out, wdat_out, halt_out
  );

endinterface

// File: rtl/mem_wb_stage_wb_select.sv
// Combinational 4:1 writeback source mux.
//   i_sel  : memtoreg_t select
//   i_alu  : ALU result
//   i_ld   : load data
//   i_lui  : LUI immediate word
//   i_pc4  : PC+4 link value
//   o_wdat : selected writeback word
module wb_select
  import cpu_types_pkg::*;
(
  input  memtoreg_t i_sel,
  input  word_t     i_alu,
  input  word_t     i_ld,
  input  word_t     i_lui,
  input  word_t     i_pc4,
  output word_t     o_wdat
);

  always_comb begin
    o_wdat = i_alu;
    unique case (i_sel)
      ALU_SEL:  o_wdat = i_alu;
      LOAD_SEL: o_wdat = i_ld;
      LUI_SEL:  o_wdat = i_lui;
      PC4_SEL:  o_wdat = i_pc4;
      default:  o_wdat = i_alu;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage + MEM/WB latch of the 5-stage pipeline.
// Issues the dcache request from the EX/MEM latch, stalls the front of the
// pipeline until the access completes, picks the writeback word and latches
// it for the register file.
//   CLK  : pipeline clock
//   nRST : asynchronous active-low reset
//   bus  : mem_wb_stage_if.slave (EX/MEM in, dcache req/resp, MEM/WB out)
module mem_wb_stage
  import cpu_types_pkg::*;
(
  input  logic           CLK,
  input  logic           nRST,
  mem_wb_stage_if.slave  bus
);

  // DONE: access finished but the pipeline has not advanced yet, so the
  // request must not be reissued. HALTED is absorbing until reset.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DONE   = 2'd1,
    HALTED = 2'd2
  } mem_state_t;

  mem_state_t r_state, w_next_state;
  word_t      r_ld_buf;
  logic       r_regwr;
  regbits_t   r_wsel;
  word_t      r_wdat;
  logic       r_halt;

  logic  w_mem_op;
  logic  w_idle;
  logic  w_mem_stall;
  logic  w_advance;
  word_t w_ld;
  word_t w_wb_mux;

  assign w_mem_op = bus.dREN_in | bus.dWEN_in;
  assign w_idle   = (r_state == IDLE);

  // Requests are gated by nRST so an in-flight access drops the moment
  // reset asserts, not at the next clock.
  assign bus.dmemREN   = nRST & bus.dREN_in & w_idle;
  assign bus.dmemWEN   = nRST & bus.dWEN_in & w_idle;
  assign bus.dmemaddr  = bus.portO_in;
  assign bus.dmemstore = bus.dmemstore_in;

  assign w_mem_stall   = nRST & w_mem_op & w_idle & ~bus.dhit;
  assign bus.mem_stall = w_mem_stall;

  assign w_advance = bus.ihit & ~w_mem_stall & (r_state != HALTED);

  // Load data bypasses the buffer in the dhit cycle so a same-cycle
  // dhit+ihit latches with no extra cycle.
  assign w_ld = bus.dhit ? bus.dmemload : r_ld_buf;

  wb_select u_wb_select (
    .i_sel  (memtoreg_t'(bus.MemToReg_in)),
    .i_alu  (bus.portO_in),
    .i_ld   (w_ld),
    .i_lui  (bus.luiValue_in),
    .i_pc4  (bus.pcp4_in),
    .o_wdat (w_wb_mux)
  );

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_advance && bus.halt_in)
          w_next_state = HALTED;
        else if (w_mem_op && bus.dhit && !bus.ihit)
          w_next_state = DONE;
        else
          w_next_state = IDLE;
      end
      DONE: begin
        if (bus.ihit)
          w_next_state = bus.halt_in ? HALTED : IDLE;
      end
      HALTED:  w_next_state = HALTED;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_ld_buf <= '0;
    end else begin
      r_state <= w_next_state;
      if (bus.dhit && w_idle)
        r_ld_buf <= bus.dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_regwr <= 1'b0;
      r_wsel  <= '0;
      r_wdat  <= '0;
      r_halt  <= 1'b0;
    end else if (w_advance) begin
      r_regwr <= bus.RegWr_in;
      r_wsel  <= bus.wsel_in;
      r_wdat  <= w_wb_mux;
      r_halt  <= bus.halt_in;
    end
  end

  assign bus.RegWr_out = r_regwr;
  assign bus.wsel_out  = r_wsel;
  assign bus.wdat_out  = r_wdat;
  assign bus.halt_out  = r_halt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU/LUI/PC+4 writeback, load miss,
// dhit-before-ihit, store, halt and reset during a pending access.
module tb_mem_wb_stage;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   checks;
  int   failures;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRST = 1'b0;
    bus.ihit = 0; bus.dhit = 0; bus.dmemload = '0;
    bus.dREN_in = 1; bus.dWEN_in = 0; bus.dmemstore_in = '0; bus.portO_in = '0;
    bus.RegWr_in = 0; bus.MemToReg_in = 2'd0; bus.luiValue_in = '0;
    bus.pcp4_in = '0; bus.wsel_in = '0; bus.halt_in = 0;
    #12;
    // reset state (load request present but held off by reset)
    chk("rst_dmemREN", 32'(bus.dmemREN), 32'd0);
    chk("rst_stall", 32'(bus.mem_stall), 32'd0);
    chk("rst_RegWr", 32'(bus.RegWr_out), 32'd0);
    chk("rst_wsel", 32'(bus.wsel_out), 32'd0);
    chk("rst_wdat", bus.wdat_out, 32'd0);
    chk("rst_halt", 32'(bus.halt_out), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'd0);
    bus.dREN_in = 0;
    nRST = 1'b1;
    tick();

    // ALU op
    bus.MemToReg_in = 2'd0; bus.portO_in = 32'h0000_00A5; bus.wsel_in = 5'd9;
    bus.RegWr_in = 1; bus.ihit = 1;
    #1 chk("alu_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    chk("alu_wdat", bus.wdat_out, 32'hA5);
    chk("alu_wsel", 32'(bus.wsel_out), 32'd9);
    chk("alu_RegWr", 32'(bus.RegWr_out), 32'd1);
    // no ihit: latch holds
    bus.ihit = 0; bus.portO_in = 32'h77; bus.wsel_in = 5'd2;
    tick();
    chk("hold_wdat", bus.wdat_out, 32'hA5);
    chk("hold_wsel", 32'(bus.wsel_out), 32'd9);

    // Load, 3-cycle miss
    bus.dREN_in = 1; bus.portO_in = 32'h100; bus.MemToReg_in = 2'd1;
    bus.wsel_in = 5'd3; bus.RegWr_in = 1; bus.ihit = 1; bus.dhit = 0;
    #1;
    chk("ld_c1_ren", 32'(bus.dmemREN), 32'd1);
    chk("ld_c1_stall", 32'(bus.mem_stall), 32'd1);
    chk("ld_c1_addr", bus.dmemaddr, 32'h100);
    tick();
    chk("ld_c1_wdat", bus.wdat_out, 32'hA5);
    chk("ld_c2_ren", 32'(bus.dmemREN), 32'd1);
    chk("ld_c2_stall", 32'(bus.mem_stall), 32'd1);
    tick();
    chk("ld_c2_wdat", bus.wdat_out, 32'hA5);
    bus.dhit = 1; bus.dmemload = 32'hDEAD_BEEF;
    #1;
    chk("ld_c3_ren", 32'(bus.dmemREN), 32'd1);
    chk("ld_c3_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    chk("ld_wdat", bus.wdat_out, 32'hDEAD_BEEF);
    chk("ld_wsel", 32'(bus.wsel_out), 32'd3);
    chk("ld_state", 32'(dut.r_state), 32'd0);

    // dhit before ihit
    bus.ihit = 0; bus.dREN_in = 1; bus.portO_in = 32'h104; bus.wsel_in = 5'd4;
    bus.dhit = 1; bus.dmemload = 32'hCAFE_F00D;
    #1 chk("dd_c1_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    chk("dd_state", 32'(dut.r_state), 32'd1);
    bus.dhit = 0; bus.dmemload = 32'h0000_0BAD;
    #1;
    chk("dd_c2_ren", 32'(bus.dmemREN), 32'd0);
    chk("dd_c2_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    chk("dd_c3_ren", 32'(bus.dmemREN), 32'd0);
    chk("dd_c3_wdat", bus.wdat_out, 32'hDEAD_BEEF);
    tick();
    bus.ihit = 1;
    #1 chk("dd_c4_ren", 32'(bus.dmemREN), 32'd0);
    tick();
    chk("dd_wdat", bus.wdat_out, 32'hCAFE_F00D);
    chk("dd_wsel", 32'(bus.wsel_out), 32'd4);
    chk("dd_state_idle", 32'(dut.r_state), 32'd0);

    // Store: miss, dhit without ihit, then ihit
    bus.dREN_in = 0; bus.dWEN_in = 1; bus.portO_in = 32'h200;
    bus.dmemstore_in = 32'h1234; bus.RegWr_in = 0; bus.MemToReg_in = 2'd0;
    bus.wsel_in = 5'd5; bus.ihit = 0; bus.dhit = 0;
    #1;
    chk("st_wen", 32'(bus.dmemWEN), 32'd1);
    chk("st_addr", bus.dmemaddr, 32'h200);
    chk("st_data", bus.dmemstore, 32'h1234);
    chk("st_stall", 32'(bus.mem_stall), 32'd1);
    tick();
    bus.dhit = 1;
    #1;
    chk("st_hit_wen", 32'(bus.dmemWEN), 32'd1);
    chk("st_hit_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    chk("st_RegWr_hold", 32'(bus.RegWr_out), 32'd1);
    bus.dhit = 0; bus.ihit = 1;
    #1 chk("st_done_wen", 32'(bus.dmemWEN), 32'd0);
    tick();
    chk("st_RegWr", 32'(bus.RegWr_out), 32'd0);
    chk("st_wdat", bus.wdat_out, 32'h200);
    chk("st_wsel", 32'(bus.wsel_out), 32'd5);

    // LUI and PC+4 selects
    bus.dWEN_in = 0; bus.RegWr_in = 1; bus.MemToReg_in = 2'd2;
    bus.luiValue_in = 32'hABCD_0000; bus.pcp4_in = 32'h40; bus.wsel_in = 5'd6;
    tick();
    chk("lui_wdat", bus.wdat_out, 32'hABCD_0000);
    bus.MemToReg_in = 2'd3; bus.wsel_in = 5'd31;
    tick();
    chk("pc4_wdat", bus.wdat_out, 32'h40);
    chk("pc4_wsel", 32'(bus.wsel_out), 32'd31);

    // Halt
    bus.MemToReg_in = 2'd0; bus.portO_in = 32'h11; bus.wsel_in = 5'd7;
    bus.halt_in = 1;
    tick();
    chk("halt_out", 32'(bus.halt_out), 32'd1);
    chk("halt_wdat", bus.wdat_out, 32'h11);
    chk("halt_state", 32'(dut.r_state), 32'd2);
    bus.halt_in = 0; bus.dREN_in = 1; bus.portO_in = 32'h300;
    bus.MemToReg_in = 2'd1; bus.wsel_in = 5'd8; bus.dhit = 0;
    #1;
    chk("halt_ren", 32'(bus.dmemREN), 32'd0);
    chk("halt_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    chk("halt_sticky", 32'(bus.halt_out), 32'd1);
    chk("halt_frozen_wdat", bus.wdat_out, 32'h11);
    chk("halt_frozen_wsel", 32'(bus.wsel_out), 32'd7);

    // Reset while a load is pending
    #2 nRST = 1'b0;
    #1;
    chk("mrst_ren", 32'(bus.dmemREN), 32'd0);
    chk("mrst_stall", 32'(bus.mem_stall), 32'd0);
    chk("mrst_halt", 32'(bus.halt_out), 32'd0);
    chk("mrst_wdat", bus.wdat_out, 32'd0);
    chk("mrst_RegWr", 32'(bus.RegWr_out), 32'd0);
    chk("mrst_state", 32'(dut.r_state), 32'd0);
    #1 nRST = 1'b1;
    #1;
    chk("reissue_ren", 32'(bus.dmemREN), 32'd1);
    chk("reissue_stall", 32'(bus.mem_stall), 32'd1);
    tick();
    bus.dhit = 1; bus.dmemload = 32'h0000_55AA;
    tick();
    chk("reissue_wdat", bus.wdat_out, 32'h55AA);
    chk("reissue_wsel", 32'(bus.wsel_out), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory stage plus MEM/WB pipeline latch of the 5-stage MIPS pipeline. It consumes the EX/MEM latch outputs and issues the data-cache request. It holds the pipeline with mem_stall until the access completes, selects the writeback word, and registers the result for the register file write port.

Parameters:
WORD_W, 32, data/address width (word_t)

Ports:
CLK  in  1  pipeline clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  icache hit; pipeline advance strobe
dhit  in  1  dcache access complete this cycle
dmemload  in  32  dcache read data, valid when dhit
dREN_in  in  1  EX/MEM load request
dWEN_in  in  1  EX/MEM store request
dmemstore_in  in  32  EX/MEM store data
portO_in  in  32  EX/MEM ALU result; also the data address
RegWr_in  in  1  EX/MEM register write enable
MemToReg_in  in  2  writeback select: 0 ALU, 1 load, 2 LUI, 3 PC+4
luiValue_in  in  32  EX/MEM LUI immediate word
pcp4_in  in  32  EX/MEM PC+4 (JAL link)
wsel_in  in  5  EX/MEM destination register
halt_in  in  1  EX/MEM halt flag
dmemREN  out  1  dcache read request
dmemWEN  out  1  dcache write request
dmemaddr  out  32  dcache address
dmemstore  out  32  dcache write data
mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
RegWr_out  out  1  MEM/WB register write enable
wsel_out  out  5  MEM/WB destination register
wdat_out  out  32  MEM/WB writeback data
halt_out  out  1  MEM/WB halt (sticky)

Behaviour:
- Interface: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values: state IDLE, ld_buf 0, RegWr_out 0, wsel_out 0, wdat_out 0, halt_out 0.
- Reset mid-access drops the request immediately (dmemREN/dmemWEN go 0 while nRST low).
- Definitions: mem_op = dREN_in | dWEN_in. FSM states: IDLE, DONE, HALTED.
- Requests (combinational):
  - dmemREN = dREN_in & state==IDLE; dmemWEN = dWEN_in & state==IDLE.
  - dmemaddr = portO_in, unmodified; dmemstore = dmemstore_in.
  - In DONE or HALTED both requests are 0. An access is never reissued after its dhit.
- mem_stall = mem_op & state==IDLE & ~dhit. mem_stall is 0 in DONE and in HALTED.
- Load data: ld = dhit ? dmemload : ld_buf. On dhit in IDLE, ld_buf <= dmemload.
- Writeback select: wsel_mux = MemToReg_in (0 portO_in, 1 ld, 2 luiValue_in, 3 pcp4_in).
- advance = ihit & ~mem_stall & state!=HALTED.
- On advance, the latch loads: RegWr_out <= RegWr_in, wsel_out <= wsel_in, wdat_out <= wsel_mux, halt_out <= halt_in. Without advance, the latch holds.
- Transitions:
  - IDLE: mem_op & dhit & ~ihit -> DONE. Advance with halt_in=1 -> HALTED. Otherwise stay IDLE.
  - DONE: on ihit, latch, then go to IDLE (or HALTED if halt_in). Otherwise stay DONE.
  - HALTED: absorbing until nRST. No requests, latch frozen, halt_out held at 1.
- Simultaneous dhit and ihit in IDLE: latch in the same cycle and stay IDLE. This gives 0 extra cycles.
- Latency:
  - Non-memory instructions: MEM/WB updated on the ihit edge.
  - Memory instructions: MEM/WB updated on the first edge where the access has completed (dhit now or earlier) and ihit=1.
- wsel_in=0 is passed through unchanged; the register file ignores writes to $0.
- dmemaddr[1:0] is not checked; word alignment is the compiler's responsibility.

Decomposition:
- cpu_types_pkg: word_t, regbits_t, and a new memtoreg_t enum (ALU_SEL, LOAD_SEL, LUI_SEL, PC4_SEL).
- Local typedef mem_state_t {IDLE, DONE, HALTED}.
- One natural sub-module: wb_select, the combinational 4:1 writeback mux over memtoreg_t.

Test Plan:
- ALU op: MemToReg=0, portO=0x0000_00A5, wsel=9, RegWr=1, ihit=1 -> next edge wdat_out=0xA5, wsel_out=9, RegWr_out=1; mem_stall stays 0.
- Load with 3-cycle miss: dREN=1, addr 0x100, dhit on cycle 3 with dmemload=0xDEAD_BEEF, ihit=1 -> mem_stall=1 for 2 cycles, dmemREN high 3 cycles, wdat_out=0xDEADBEEF after the cycle-3 edge.
- dhit before ihit: dhit cycle 1, ihit cycle 4 -> state DONE, dmemREN=0 for cycles 2-4, wdat_out equals ld_buf value after the cycle-4 edge.
- Store: dWEN=1, addr 0x200, data 0x1234 -> dmemWEN=1, dmemaddr=0x200, dmemstore=0x1234 until dhit, then 0. RegWr_out follows RegWr_in=0.
- Halt: halt_in=1 with ihit -> halt_out=1 sticky; a subsequent load request produces dmemREN=0 and the latch is unchanged.
- Reset mid-access: nRST low during a pending load -> all outputs 0 asynchronously, state IDLE; after release the load reissues.
